// File: rtl/pe_window_controller_if.sv
// Bus between the display timing generator / register file and the window sequencer.
// The master drives the timing strobes and geometry registers; the slave returns region flags.
interface pe_window_controller_if;
  logic        line_start;
  logic        pixel_en;
  logic [7:0]  vcount;
  logic [15:0] WIN0H;
  logic [15:0] WIN1H;
  logic [15:0] WIN0V;
  logic [15:0] WIN1V;
  logic [15:0] DISPCNT;
  logic        obj_win_in;
  logic        WIN0;
  logic        WIN1;
  logic        obj;
  logic [7:0]  x_out;
  logic        valid;

  modport master (
    output line_start, pixel_en, vcount, WIN0H, WIN1H, WIN0V, WIN1V, DISPCNT, obj_win_in,
    input  WIN0, WIN1, obj, x_out, valid
  );

  modport slave (
    input  line_start, pixel_en, vcount, WIN0H, WIN1H, WIN0V, WIN1V, DISPCNT, obj_win_in,
    output WIN0, WIN1, obj, x_out, valid
  );
endinterface

// File: rtl/pe_window_controller.sv
// Per-pixel window-region sequencer: shadows window geometry per scanline, emits registered WIN0/WIN1/obj flags.
// Optional macro PE_WIN_CLAMP_EN clamps X2 to 240 and Y2 to 160 before the interval test.
module pe_window_controller (
  input  logic                   clock,
  input  logic                   reset,
  pe_window_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK
  } state_t;

  localparam logic [7:0] LAST_X  = 8'd239;
  localparam logic [7:0] VIS_W   = 8'd240;
  localparam logic [7:0] VIS_H   = 8'd160;

  state_t      state;
  state_t      state_next;

  logic [7:0]  x;
  logic [15:0] win0h_s;
  logic [15:0] win1h_s;
  logic [2:0]  en_s;
  logic        vin0;
  logic        vin1;

  logic        accept;
  logic        hin0;
  logic        hin1;
  logic        w0_d;
  logic        w1_d;
  logic        obj_d;
  logic        vin0_d;
  logic        vin1_d;

  logic        unused_dispcnt;
  assign unused_dispcnt = ^bus.DISPCNT[12:0];

  // Half-open interval [a, b) on an 8-bit axis; a > b wraps around, a == b is empty.
  function automatic logic in_span(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b);
    if (a < b)
      return (p >= a) && (p < b);
    else if (a > b)
      return (p >= a) || (p < b);
    else
      return 1'b0;
  endfunction

  function automatic logic [7:0] lim_x2(input logic [7:0] v);
`ifdef PE_WIN_CLAMP_EN
    return (v > VIS_W) ? VIS_W : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] lim_y2(input logic [7:0] v);
`ifdef PE_WIN_CLAMP_EN
    return (v > VIS_H) ? VIS_H : v;
`else
    return v;
`endif
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; line_start wins over pixel_en in every state
  always_comb begin
    state_next = state;
    if (bus.line_start)
      state_next = ACTIVE;
    else if (accept && (x == LAST_X))
      state_next = HBLANK;
  end

  // Output decode: pixel acceptance and next flag values
  always_comb begin
    accept = 1'b0;
    hin0   = 1'b0;
    hin1   = 1'b0;
    w0_d   = 1'b0;
    w1_d   = 1'b0;
    obj_d  = 1'b0;
    vin0_d = 1'b0;
    vin1_d = 1'b0;

    accept = (state == ACTIVE) && bus.pixel_en && !bus.line_start;

    hin0  = in_span(x, win0h_s[15:8], lim_x2(win0h_s[7:0]));
    hin1  = in_span(x, win1h_s[15:8], lim_x2(win1h_s[7:0]));
    w0_d  = en_s[0] && vin0 && hin0;
    w1_d  = en_s[1] && vin1 && hin1 && !w0_d;
    obj_d = en_s[2] && bus.obj_win_in && !w0_d && !w1_d;

    if (bus.vcount < VIS_H) begin
      vin0_d = in_span(bus.vcount, bus.WIN0V[15:8], lim_y2(bus.WIN0V[7:0]));
      vin1_d = in_span(bus.vcount, bus.WIN1V[15:8], lim_y2(bus.WIN1V[7:0]));
    end
  end

  // Datapath: shadows latch on line_start, flags update only on accepted pixels and hold otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      x         <= '0;
      win0h_s   <= '0;
      win1h_s   <= '0;
      en_s      <= '0;
      vin0      <= 1'b0;
      vin1      <= 1'b0;
      bus.WIN0  <= 1'b0;
      bus.WIN1  <= 1'b0;
      bus.obj   <= 1'b0;
      bus.x_out <= '0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= accept;
      if (bus.line_start) begin
        x       <= '0;
        win0h_s <= bus.WIN0H;
        win1h_s <= bus.WIN1H;
        en_s    <= bus.DISPCNT[15:13];
        vin0    <= vin0_d;
        vin1    <= vin1_d;
      end else if (accept) begin
        x         <= x + 8'd1;
        bus.x_out <= x;
        bus.WIN0  <= w0_d;
        bus.WIN1  <= w1_d;
        bus.obj   <= obj_d;
      end
    end
  end

endmodule

// File: tb/tb_pe_window_controller.sv
// Self-checking bench for pe_window_controller: directed test-plan lines plus random traffic,
// compared every cycle against a modular-arithmetic reference model.
module tb_pe_window_controller;

  logic clock;
  logic reset;

  pe_window_controller_if ifc ();

  pe_window_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit m_act;
  int m_x;
  int m_h0, m_h1;
  bit [2:0] m_en;
  bit m_v0, m_v1;
  bit m_w0, m_w1, m_obj, m_valid;
  int m_xo;

  // Per-line observation counters
  int valid_cnt, w0_hits, w1_hits, obj_hits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Membership in [a, b) modulo 256: distance from a is shorter than the window length.
  function automatic bit m_inside(int p, int a, int b);
    return ((p - a + 256) % 256) < ((b - a + 256) % 256);
  endfunction

  function automatic int m_x2(int v);
`ifdef PE_WIN_CLAMP_EN
    return (v > 240) ? 240 : v;
`else
    return v;
`endif
  endfunction

  function automatic int m_y2(int v);
`ifdef PE_WIN_CLAMP_EN
    return (v > 160) ? 160 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    bit h0, h1;
    @(posedge clock);
    if (reset) begin
      m_act = 0; m_x = 0; m_h0 = 0; m_h1 = 0; m_en = '0; m_v0 = 0; m_v1 = 0;
      m_w0 = 0; m_w1 = 0; m_obj = 0; m_xo = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (ifc.line_start) begin
        m_act = 1;
        m_x   = 0;
        m_h0  = int'(ifc.WIN0H);
        m_h1  = int'(ifc.WIN1H);
        m_en  = ifc.DISPCNT[15:13];
        m_v0  = (ifc.vcount < 160) && m_inside(ifc.vcount, ifc.WIN0V[15:8], m_y2(ifc.WIN0V[7:0]));
        m_v1  = (ifc.vcount < 160) && m_inside(ifc.vcount, ifc.WIN1V[15:8], m_y2(ifc.WIN1V[7:0]));
      end else if (m_act && ifc.pixel_en) begin
        h0    = m_inside(m_x, m_h0 / 256, m_x2(m_h0 % 256));
        h1    = m_inside(m_x, m_h1 / 256, m_x2(m_h1 % 256));
        m_w0  = m_en[0] && m_v0 && h0;
        m_w1  = m_en[1] && m_v1 && h1 && !m_w0;
        m_obj = m_en[2] && ifc.obj_win_in && !m_w0 && !m_w1;
        m_valid = 1;
        m_xo  = m_x;
        m_x++;
        if (m_x == 240) m_act = 0;
      end
    end
    #1;
    check("valid", ifc.valid, m_valid);
    check("x_out", ifc.x_out, m_xo);
    check("WIN0",  ifc.WIN0,  m_w0);
    check("WIN1",  ifc.WIN1,  m_w1);
    check("obj",   ifc.obj,   m_obj);
    if (ifc.valid) begin
      valid_cnt++;
      if (ifc.WIN0) w0_hits++;
      if (ifc.WIN1) w1_hits++;
      if (ifc.obj)  obj_hits++;
    end
  endtask

  task automatic start_line(input int vc);
    ifc.line_start = 1'b1;
    ifc.pixel_en   = 1'b0;
    ifc.vcount     = 8'(vc);
    tick();
    ifc.line_start = 1'b0;
    valid_cnt = 0; w0_hits = 0; w1_hits = 0; obj_hits = 0;
  endtask

  task automatic run_px(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.pixel_en = 1'b1;
      tick();
    end
    ifc.pixel_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifc.line_start = 0; ifc.pixel_en = 0; ifc.vcount = '0; ifc.obj_win_in = 0;
    ifc.WIN0H = '0; ifc.WIN1H = '0; ifc.WIN0V = '0; ifc.WIN1V = '0; ifc.DISPCNT = '0;
    tick();
    tick();
    check("rst_valid", ifc.valid, 0);
    check("rst_flags", {ifc.WIN0, ifc.WIN1, ifc.obj}, 0);
    reset = 1'b0;
    run_px(3);

    // Basic window 10..31 on line 10; extra strobes in HBLANK are ignored
    ifc.WIN0V = 16'h0514; ifc.WIN0H = 16'h0A20; ifc.DISPCNT = 16'h2000;
    start_line(10);
    run_px(240);
    check("t1_valid_cnt", valid_cnt, 240);
    check("t1_w0_hits", w0_hits, 22);
    run_px(4);
    check("t1_hblank_ignored", valid_cnt, 240);

    // Wrap-around and empty windows
    ifc.WIN0H = 16'hE010;
    start_line(12);
    run_px(240);
    check("wrap_hits", w0_hits, 32);
    ifc.WIN0H = 16'h3030;
    start_line(12);
    run_px(240);
    check("empty_hits", w0_hits, 0);

    // Overlap priority, then a wider WIN1 around WIN0
    ifc.WIN0H = 16'h323C; ifc.WIN1H = 16'h323C; ifc.WIN1V = 16'h0514;
    ifc.DISPCNT = 16'hE000; ifc.obj_win_in = 1'b1;
    start_line(12);
    run_px(240);
    check("ovl_w0", w0_hits, 10);
    check("ovl_w1", w1_hits, 0);
    check("ovl_obj", obj_hits, 230);
    ifc.WIN1H = 16'h2846;
    start_line(12);
    run_px(240);
    check("ovl2_w1", w1_hits, 20);
    check("ovl2_obj", obj_hits, 210);
    ifc.obj_win_in = 1'b0; ifc.DISPCNT = 16'h2000;

    // Shadowing: mid-line write has no effect; line_start with pixel_en restarts at 0
    ifc.WIN0H = 16'h0A20;
    start_line(10);
    run_px(100);
    ifc.WIN0H = 16'h6480;
    run_px(20);
    check("shadow_hits", w0_hits, 22);
    ifc.line_start = 1'b1; ifc.pixel_en = 1'b1;
    tick();
    ifc.line_start = 1'b0;
    check("abort_valid", ifc.valid, 0);
    run_px(1);
    check("abort_x0", ifc.x_out, 0);
    run_px(239);

    // Clamp boundary cases
    ifc.WIN0H = 16'h00FF;
    start_line(10);
    run_px(240);
    check("clamp_full", w0_hits, 240);
    ifc.WIN0H = 16'hF8FF;
    start_line(10);
    run_px(240);
`ifdef PE_WIN_CLAMP_EN
    check("clamp_wrap", w0_hits, 240);
`else
    check("clamp_wrap", w0_hits, 0);
`endif
    ifc.WIN0H = 16'h00FF; ifc.WIN0V = 16'h00C8;
    start_line(170);
    run_px(240);
    check("v_offscreen", w0_hits, 0);

    // Reset mid-line, then strobes ignored until line_start
    ifc.WIN0V = 16'h0514;
    start_line(10);
    run_px(80);
    reset = 1'b1; ifc.pixel_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_flags", {ifc.valid, ifc.WIN0, ifc.WIN1, ifc.obj}, 0);
    valid_cnt = 0;
    run_px(5);
    check("rst_mid_ignored", valid_cnt, 0);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      reset          = ($urandom_range(0, 399) == 0);
      ifc.line_start = ($urandom_range(0, 199) < 3);
      ifc.pixel_en   = ($urandom_range(0, 9) < 8);
      ifc.vcount     = 8'($urandom_range(0, 227));
      ifc.obj_win_in = 1'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        ifc.WIN0H   = 16'($urandom);
        ifc.WIN1H   = 16'($urandom);
        ifc.WIN0V   = 16'($urandom);
        ifc.WIN1V   = 16'($urandom);
        ifc.DISPCNT = 16'($urandom);
      end
      tick();
    end
    reset = 1'b0; ifc.line_start = 1'b0; ifc.pixel_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
